// File: rtl/sound_gen_multi_pkg.sv
// Shared definitions for the multi-voice sound generator: register map,
// CTRL field layout, mixer/envelope source codes, reset defaults and the noise LFSR step.
package sound_gen_multi_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_VCO_MIN = 3'd1;
    localparam logic [2:0] REG_VCO_MAX = 3'd2;
    localparam logic [2:0] REG_ATTACK  = 3'd3;
    localparam logic [2:0] REG_DECAY   = 3'd4;
    localparam logic [2:0] REG_OS_LEN  = 3'd5;

    localparam int CTRL_MIX_LSB   = 0;
    localparam int CTRL_ENV_LSB   = 3;
    localparam int CTRL_VCO_SEL   = 5;
    localparam int CTRL_VCO_PITCH = 6;

    typedef enum logic [2:0] {
        MIX_VCO       = 3'd0,
        MIX_SLF       = 3'd1,
        MIX_NOISE     = 3'd2,
        MIX_VCO_N     = 3'd3,
        MIX_SLF_N     = 3'd4,
        MIX_SLF_VCO_N = 3'd5,
        MIX_SLF_VCO   = 3'd6,
        MIX_ONE       = 3'd7
    } mix_e;

    typedef enum logic [1:0] {
        ENV_VCO     = 2'd0,
        ENV_ONE     = 2'd1,
        ENV_ONESHOT = 2'd2,
        ENV_VCO2    = 2'd3
    } envsel_e;

    localparam logic [15:0] LFSR_TAP    = 16'h54B9;
    localparam logic [6:0]  CTRL_RST    = 7'h08;
    localparam logic [15:0] VCO_MIN_RST = 16'd937;
    localparam logic [15:0] VCO_MAX_RST = 16'd9374;
    localparam logic [15:0] ATTACK_RST  = 16'd20;
    localparam logic [15:0] DECAY_RST   = 16'd1;
    localparam logic [15:0] OS_LEN_RST  = 16'd1624;

    // A zero state is re-seeded through the feedback bit so the LFSR never locks up.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {s[14:0], (s == 16'h0000)} ^ (s[15] ? LFSR_TAP : 16'h0000);
    endfunction

endpackage

// File: rtl/sound_gen_multi_if.sv
// CPU-side register write bus plus the mixed sample stream towards the serialiser.
interface sound_gen_multi_if #(parameter int OUT_W = 16);
    logic             wr_en;
    logic [2:0]       wr_ch;
    logic [2:0]       wr_addr;
    logic [15:0]      wr_data;
    logic [OUT_W-1:0] sample_out;
    logic             sample_valid;

    modport master (output wr_en, wr_ch, wr_addr, wr_data, input sample_out, sample_valid);
    modport slave  (input wr_en, wr_ch, wr_addr, wr_data, output sample_out, sample_valid);
endinterface

// File: rtl/sound_gen_multi_voice.sv
// One voice: parameter registers, SLF, VCO, noise LFSR, one-shot, attack/decay envelope and mixer.
module sound_gen_multi_voice
    import sound_gen_multi_pkg::*;
#(
    parameter int          MAG_W     = 14,
    parameter int          PIT_W     = 14,
    parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb_16us,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [15:0]      wr_data,
    input  logic             inhibit,
    output logic [MAG_W-1:0] mag
);

    logic [6:0]       ctrl_r;
    logic [PIT_W-1:0] vco_min_r, vco_max_r, slf_ctr_r, vco_ctr_r, pitch_s;
    logic [MAG_W-1:0] attack_r, decay_r, env_r, env_next_s;
    logic [MAG_W:0]   env_sum_s;
    logic [15:0]      os_len_r, os_ctr_r, lfsr_r;
    logic [1:0]       vco_cyc_r;
    logic             slf_up_r, inh_d_r, oneshot_r, env_in_s, mix_s;
    logic             vco_s, vco2_s, noise_s;

    assign vco_s   = vco_cyc_r[0];
    assign vco2_s  = vco_cyc_r[0] & vco_cyc_r[1];
    assign noise_s = lfsr_r[15];

    // Register slice; reserved addresses fall through without effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r    <= CTRL_RST;
            vco_min_r <= PIT_W'(VCO_MIN_RST);
            vco_max_r <= PIT_W'(VCO_MAX_RST);
            attack_r  <= MAG_W'(ATTACK_RST);
            decay_r   <= MAG_W'(DECAY_RST);
            os_len_r  <= OS_LEN_RST;
        end else if (wr_en) begin
            case (wr_addr)
                REG_CTRL:    ctrl_r    <= wr_data[6:0];
                REG_VCO_MIN: vco_min_r <= wr_data[PIT_W-1:0];
                REG_VCO_MAX: vco_max_r <= wr_data[PIT_W-1:0];
                REG_ATTACK:  attack_r  <= wr_data[MAG_W-1:0];
                REG_DECAY:   decay_r   <= wr_data[MAG_W-1:0];
                REG_OS_LEN:  os_len_r  <= wr_data;
                default:     ctrl_r    <= ctrl_r;
            endcase
        end
    end

    // SLF triangle between VCO_MIN and VCO_MAX; degenerate or out-of-range limits pin the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slf_ctr_r <= PIT_W'(VCO_MIN_RST);
            slf_up_r  <= 1'b1;
        end else if (stb_16us) begin
            if (vco_min_r >= vco_max_r) begin
                slf_ctr_r <= vco_min_r;
                slf_up_r  <= 1'b1;
            end else if (slf_ctr_r < vco_min_r) begin
                slf_ctr_r <= vco_min_r;
                slf_up_r  <= 1'b1;
            end else if (slf_ctr_r > vco_max_r) begin
                slf_ctr_r <= vco_max_r;
                slf_up_r  <= 1'b0;
            end else if (slf_up_r && (slf_ctr_r >= vco_max_r)) begin
                slf_ctr_r <= slf_ctr_r - PIT_W'(1);
                slf_up_r  <= 1'b0;
            end else if (!slf_up_r && (slf_ctr_r <= vco_min_r)) begin
                slf_ctr_r <= slf_ctr_r + PIT_W'(1);
                slf_up_r  <= 1'b1;
            end else if (slf_up_r) begin
                slf_ctr_r <= slf_ctr_r + PIT_W'(1);
            end else begin
                slf_ctr_r <= slf_ctr_r - PIT_W'(1);
            end
        end
    end

    // Pitch source for the VCO reload
    always_comb begin
        if (ctrl_r[CTRL_VCO_SEL]) begin
            pitch_s = slf_ctr_r;
        end else if (ctrl_r[CTRL_VCO_PITCH]) begin
            pitch_s = vco_max_r;
        end else begin
            pitch_s = vco_min_r;
        end
    end

    // VCO runs every clock: half-period is pitch+1 clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vco_ctr_r <= {PIT_W{1'b0}};
            vco_cyc_r <= 2'b00;
        end else if (vco_ctr_r == {PIT_W{1'b0}}) begin
            vco_ctr_r <= pitch_s;
            vco_cyc_r <= vco_cyc_r + 2'd1;
        end else begin
            vco_ctr_r <= vco_ctr_r - PIT_W'(1);
        end
    end

    // Noise LFSR advances on the slow tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (stb_16us) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // One-shot retriggered by every inhibit release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inh_d_r   <= 1'b0;
            os_ctr_r  <= 16'd0;
            oneshot_r <= 1'b0;
        end else begin
            inh_d_r   <= inhibit;
            oneshot_r <= (os_ctr_r != 16'd0);
            if (inh_d_r && !inhibit) begin
                os_ctr_r <= os_len_r;
            end else if (stb_16us && (os_ctr_r != 16'd0)) begin
                os_ctr_r <= os_ctr_r - 16'd1;
            end
        end
    end

    // Envelope source select, mixer and the saturating attack/decay step
    always_comb begin
        case (envsel_e'(ctrl_r[CTRL_ENV_LSB +: 2]))
            ENV_VCO:     env_in_s = vco_s;
            ENV_ONE:     env_in_s = 1'b1;
            ENV_ONESHOT: env_in_s = oneshot_r;
            ENV_VCO2:    env_in_s = vco2_s;
            default:     env_in_s = 1'b0;
        endcase
        case (mix_e'(ctrl_r[CTRL_MIX_LSB +: 3]))
            MIX_VCO:       mix_s = vco_s;
            MIX_SLF:       mix_s = slf_up_r;
            MIX_NOISE:     mix_s = noise_s;
            MIX_VCO_N:     mix_s = vco_s & noise_s;
            MIX_SLF_N:     mix_s = slf_up_r & noise_s;
            MIX_SLF_VCO_N: mix_s = slf_up_r & vco_s & noise_s;
            MIX_SLF_VCO:   mix_s = slf_up_r & vco_s;
            MIX_ONE:       mix_s = 1'b1;
            default:       mix_s = 1'b0;
        endcase
        env_sum_s = {1'b0, env_r} + {1'b0, attack_r};
        if (env_in_s) begin
            if (env_sum_s[MAG_W]) begin
                env_next_s = {MAG_W{1'b1}};
            end else begin
                env_next_s = env_sum_s[MAG_W-1:0];
            end
        end else begin
            if (env_r < decay_r) begin
                env_next_s = {MAG_W{1'b0}};
            end else begin
                env_next_s = env_r - decay_r;
            end
        end
    end

    // Envelope magnitude register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_r <= {MAG_W{1'b0}};
        end else if (stb_16us) begin
            env_r <= env_next_s;
        end
    end

    assign mag = (!inhibit && mix_s) ? env_r : {MAG_W{1'b0}};

endmodule

// File: rtl/sound_gen_multi.sv
// NCH-voice sound generator top: write decode, voice array, saturating mix and sample register.
module sound_gen_multi
    import sound_gen_multi_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int MAG_W = 14,
    parameter int OUT_W = 16,
    parameter int PIT_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stb_16us,
    input  logic [NCH-1:0]    inhibit,
    sound_gen_multi_if.slave  bus
);

    localparam int SUM_W = MAG_W + $clog2(NCH);
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [CMP_W-1:0] SAT_MAX = CMP_W'({OUT_W{1'b1}});

    logic [NCH-1:0]   we_s;
    logic [MAG_W-1:0] mag_s [NCH];
    logic [SUM_W-1:0] sum_s;
    logic [CMP_W-1:0] sum_wide_s;
    logic [OUT_W-1:0] sat_s, sample_r;
    logic             valid_r;

    // Voice select; channel numbers beyond the array match nothing
    always_comb begin
        for (int v = 0; v < NCH; v++) begin
            if (bus.wr_en && (bus.wr_ch == 3'(v))) begin
                we_s[v] = 1'b1;
            end else begin
                we_s[v] = 1'b0;
            end
        end
    end

    for (genvar v = 0; v < NCH; v++) begin : g_voice
        sound_gen_multi_voice #(
            .MAG_W    (MAG_W),
            .PIT_W    (PIT_W),
            .LFSR_SEED(16'hFFFF ^ 16'(v))
        ) u_voice (
            .clk     (clk),
            .rst_n   (rst_n),
            .stb_16us(stb_16us),
            .wr_en   (we_s[v]),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .inhibit (inhibit[v]),
            .mag     (mag_s[v])
        );
    end

    // Sum is wide enough never to wrap; clamp it to the output range
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int v = 0; v < NCH; v++) begin
            sum_s = sum_s + SUM_W'(mag_s[v]);
        end
        sum_wide_s = CMP_W'(sum_s);
        if (sum_wide_s > SAT_MAX) begin
            sat_s = SAT_MAX[OUT_W-1:0];
        end else begin
            sat_s = sum_wide_s[OUT_W-1:0];
        end
    end

    // Sample register and its one-cycle valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r <= {OUT_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            valid_r <= stb_16us;
            if (stb_16us) begin
                sample_r <= sat_s;
            end
        end
    end

    assign bus.sample_out   = sample_r;
    assign bus.sample_valid = valid_r;

endmodule

// File: tb/tb_sound_gen_multi.sv
// Directed bench for sound_gen_multi: a 16-bit-output and a 14-bit-output instance share stimulus.
module tb_sound_gen_multi;

    logic        clk;
    logic        rst_n;
    logic        stb_16us;
    logic [1:0]  inhibit;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_s;
    logic [13:0] last_s14;
    logic        last_v;

    sound_gen_multi_if #(.OUT_W(16)) bus16 ();
    sound_gen_multi_if #(.OUT_W(14)) bus14 ();

    assign bus16.wr_en   = wr_en;
    assign bus16.wr_ch   = wr_ch;
    assign bus16.wr_addr = wr_addr;
    assign bus16.wr_data = wr_data;
    assign bus14.wr_en   = wr_en;
    assign bus14.wr_ch   = wr_ch;
    assign bus14.wr_addr = wr_addr;
    assign bus14.wr_data = wr_data;

    sound_gen_multi #(.NCH(2), .MAG_W(14), .OUT_W(16), .PIT_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .stb_16us(stb_16us), .inhibit(inhibit), .bus(bus16.slave)
    );

    sound_gen_multi #(.NCH(2), .MAG_W(14), .OUT_W(14), .PIT_W(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .stb_16us(stb_16us), .inhibit(inhibit), .bus(bus14.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stb_16us = 1'b0;
        inhibit  = 2'b00;
        wr_en    = 1'b0;
        wr_ch    = 3'd0;
        wr_addr  = 3'd0;
        wr_data  = 16'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Optional tick in the same cycle as the write; sample captured one clock later
    task automatic wr(input logic [2:0] ch, input logic [2:0] addr, input logic [15:0] data, input logic tk);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_ch    = ch;
        wr_addr  = addr;
        wr_data  = data;
        stb_16us = tk;
        @(negedge clk);
        wr_en    = 1'b0;
        stb_16us = 1'b0;
        last_s   = bus16.sample_out;
        last_s14 = bus14.sample_out;
        last_v   = bus16.sample_valid;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        stb_16us = 1'b1;
        @(negedge clk);
        stb_16us = 1'b0;
        last_s   = bus16.sample_out;
        last_s14 = bus14.sample_out;
        last_v   = bus16.sample_valid;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vco_rise(output int n);
        logic prev, cur;
        prev = dut.g_voice[0].u_voice.vco_s;
        n = 0;
        while (n < 40000) begin
            @(negedge clk);
            n++;
            cur = dut.g_voice[0].u_voice.vco_s;
            if (!prev && cur) break;
            prev = cur;
        end
    endtask

    initial begin
        int n;
        int env_m, os_m, os_cnt;

        // Saturating ramp on both voices, plus 14-bit clamp
        do_reset();
        check_eq("rst_sample", bus16.sample_out, 32'd0);
        check_eq("rst_valid", bus16.sample_valid, 32'd0);
        wr(3'd0, 3'd0, 16'h000F, 1'b0);
        wr(3'd1, 3'd0, 16'h000F, 1'b0);
        tick();
        check_eq("t1_valid", last_v, 32'd1);
        check_eq("t1_sample", last_s, 32'd0);
        check_eq("valid_drop", bus16.sample_valid, 32'd0);
        tick();
        check_eq("t2_sample", last_s, 32'd40);
        tick();
        check_eq("t3_sample", last_s, 32'd80);
        check_eq("t3_sample14", last_s14, 32'd80);
        for (int i = 4; i <= 830; i++) begin
            tick();
            if (i == 412) begin
                check_eq("t412_sample", last_s, 32'd16440);
                check_eq("t412_clamp14", last_s14, 32'h3FFF);
            end
        end
        check_eq("sat_sample", last_s, 32'h7FFE);
        check_eq("sat_clamp14", last_s14, 32'h3FFF);

        // Asynchronous reset mid-ramp
        do_reset();
        wr(3'd0, 3'd0, 16'h000F, 1'b0);
        wr(3'd1, 3'd3, 16'd7, 1'b0);
        repeat (10) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_sample", bus16.sample_out, 32'd0);
        check_eq("arst_ctrl0", dut.g_voice[0].u_voice.ctrl_r, 32'h08);
        check_eq("arst_attack1", dut.g_voice[1].u_voice.attack_r, 32'd20);
        check_eq("arst_env0", dut.g_voice[0].u_voice.env_r, 32'd0);
        check_eq("arst_lfsr1", dut.g_voice[1].u_voice.lfsr_r, 32'hFFFE);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_valid", last_v, 32'd1);
        check_eq("post_rst_sample", last_s, 32'd0);
        check_eq("lfsr1_step", dut.g_voice[1].u_voice.lfsr_r, 32'hAB45);

        // Write colliding with a tick, and out-of-range channel writes
        do_reset();
        inhibit = 2'b10;
        wr(3'd0, 3'd0, 16'h000F, 1'b0);
        tick(); tick(); tick();
        check_eq("t3_pre", last_s, 32'd40);
        wr(3'd0, 3'd0, 16'h0017, 1'b1);
        check_eq("coll_tick", last_s, 32'd60);
        tick();
        check_eq("old_env_used", last_s, 32'd80);
        tick();
        check_eq("new_env_used", last_s, 32'd79);
        wr(3'd7, 3'd0, 16'h0000, 1'b0);
        wr(3'd2, 3'd0, 16'h0000, 1'b0);
        tick();
        check_eq("bad_ch_sample", last_s, 32'd78);
        check_eq("bad_ch_ctrl0", dut.g_voice[0].u_voice.ctrl_r, 32'h17);
        check_eq("bad_ch_ctrl1", dut.g_voice[1].u_voice.ctrl_r, 32'h08);

        // SLF hold with inverted limits, then triangle turnaround
        do_reset();
        wr(3'd0, 3'd1, 16'd500, 1'b0);
        wr(3'd0, 3'd2, 16'd400, 1'b0);
        repeat (3) tick();
        check_eq("slf_hold_ctr", dut.g_voice[0].u_voice.slf_ctr_r, 32'd500);
        check_eq("slf_hold_up", dut.g_voice[0].u_voice.slf_up_r, 32'd1);
        wr(3'd0, 3'd2, 16'd600, 1'b0);
        for (int i = 1; i <= 201; i++) begin
            tick();
            if (i == 100 || i == 101 || i == 200 || i == 201) begin
                check_eq($sformatf("slf_ctr_%0d", i), dut.g_voice[0].u_voice.slf_ctr_r,
                         (i == 100) ? 32'd600 : (i == 101) ? 32'd599 : (i == 200) ? 32'd500 : 32'd501);
                check_eq($sformatf("slf_up_%0d", i), dut.g_voice[0].u_voice.slf_up_r,
                         (i == 100 || i == 201) ? 32'd1 : 32'd0);
            end
        end

        // One-shot envelope: attack 1/tick for 1624 ticks, decay 1/tick, floor at 0
        do_reset();
        inhibit = 2'b10;
        wr(3'd0, 3'd0, 16'h0017, 1'b0);
        wr(3'd0, 3'd3, 16'd1, 1'b0);
        @(negedge clk) inhibit = 2'b11;
        repeat (2) @(negedge clk);
        inhibit = 2'b10;
        repeat (3) @(negedge clk);
        env_m  = 0;
        os_m   = 1624;
        os_cnt = 0;
        for (int i = 1; i <= 3260; i++) begin
            if (dut.g_voice[0].u_voice.oneshot_r) os_cnt++;
            tick();
            if (i < 3 || (i > 1622 && i < 1628) || i > 3246) begin
                check_eq($sformatf("os_env_t%0d", i), last_s, env_m);
            end
            if (os_m != 0) begin
                env_m = (env_m < 16383) ? env_m + 1 : 16383;
                os_m--;
            end else begin
                env_m = (env_m > 0) ? env_m - 1 : 0;
            end
        end
        check_eq("oneshot_ticks", os_cnt, 32'd1624);

        // VCO period from VCO_MAX, then a shortened MAX from the next reload
        do_reset();
        wr(3'd0, 3'd0, 16'h0048, 1'b0);
        wait_vco_rise(n);
        wait_vco_rise(n);
        check_eq("vco_period_max", n, 32'd18750);
        wr(3'd0, 3'd2, 16'd100, 1'b0);
        wait_vco_rise(n);
        wait_vco_rise(n);
        check_eq("vco_period_100", n, 32'd202);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
